// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy scoreboard: tracks outstanding multi-cycle writes and
// gates new claims to a register that still has one pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = 2,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  input  logic                     we3,
  input  logic [ADDR_W-1:0]        wa3,
  input  logic                     claim_valid,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic                     flush,
  output logic                     claim_ready,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     busy_any
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             claim_to_r0;
  logic             claim_take;

  // A retiring write on the claimed register frees it in the same cycle.
  assign claim_ready = claim_valid & ~flush &
                       (~busy_q[claim_addr] | (we3 & (wa3 == claim_addr)));
  assign claim_to_r0 = (R0_ZERO != 0) && (claim_addr == ADDR_W'(REG_ZERO));
  assign claim_take  = claim_ready & ~claim_to_r0;
  assign busy_any    = |busy_q;

  // Claim is applied after the write clear so a same-cycle claim wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (we3)        busy_d[wa3]        = 1'b0;
      if (claim_take) busy_d[claim_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    a       = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a          = ra[i*ADDR_W +: ADDR_W];
      rd_busy[i] = busy_q[a] & ~((BYPASS != 0) & we3 & (wa3 == a));
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-port register file with optional r0 hardwiring,
// write-to-read bypass and a busy scoreboard for outstanding writes.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = 2,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we3,
  input  logic [ADDR_W-1:0]        wa3,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     claim_valid,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     claim_ready,
  input  logic                     flush,
  output logic                     busy_any
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf [DEPTH];
  logic              wr_ok;

  // Writes to a hardwired r0 are dropped, including for bypass purposes.
  assign wr_ok = we3 & ~((R0_ZERO != 0) && (wa3 == ADDR_W'(REG_ZERO)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (wr_ok) begin
      rf[wa3] <= write_data;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    a         = '0;
    read_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = ra[i*ADDR_W +: ADDR_W];
      if ((R0_ZERO != 0) && (a == ADDR_W'(REG_ZERO)))
        read_data[i*DATA_W +: DATA_W] = '0;
      else if ((BYPASS != 0) && wr_ok && (wa3 == a))
        read_data[i*DATA_W +: DATA_W] = write_data;
      else
        read_data[i*DATA_W +: DATA_W] = rf[a];
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .R0_ZERO (R0_ZERO),
    .BYPASS  (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .ra          (ra),
    .we3         (we3),
    .wa3         (wa3),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .flush       (flush),
    .claim_ready (claim_ready),
    .rd_busy     (rd_busy),
    .busy_any    (busy_any)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 4-port bypassing instance and a 2-port
// non-bypassing instance share stimulus and are checked against one model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] ra;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] write_data;
  logic        claim_valid;
  logic [4:0]  claim_addr;
  logic        flush;

  logic [127:0] rd_a;
  logic [3:0]   busy_a;
  logic         cr_a, ba_a;
  logic [63:0]  rd_b;
  logic [1:0]   busy_b;
  logic         cr_b, ba_b;

  int tests = 0;
  int fails = 0;

  // Reference state: register contents and outstanding-claim flags.
  logic [31:0] mem [32];
  bit          pend [32];

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .R0_ZERO(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ra(ra), .read_data(rd_a), .rd_busy(busy_a),
    .we3(we3), .wa3(wa3), .write_data(write_data),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(cr_a),
    .flush(flush), .busy_any(ba_a)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .R0_ZERO(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .ra(ra[9:0]), .read_data(rd_b), .rd_busy(busy_b),
    .we3(we3), .wa3(wa3), .write_data(write_data),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(cr_b),
    .flush(flush), .busy_any(ba_b)
  );

  function automatic logic [31:0] exp_read(input logic [4:0] r, input bit byp);
    if (r == 5'd0) return 32'h0;
    if (byp && we3 && wa3 == r) return write_data;
    return mem[r];
  endfunction

  function automatic logic exp_busy(input logic [4:0] r, input bit byp);
    return pend[r] && !(byp && we3 && wa3 == r);
  endfunction

  function automatic logic exp_ready();
    return claim_valid && !flush && (!pend[claim_addr] || (we3 && wa3 == claim_addr));
  endfunction

  function automatic logic exp_any();
    for (int i = 0; i < 32; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4:0] r;
    for (int i = 0; i < 4; i++) begin
      r = ra[i*5 +: 5];
      chk($sformatf("rd_a[%0d] r%0d", i, r), rd_a[i*32 +: 32], exp_read(r, 1'b1));
      chk($sformatf("busy_a[%0d] r%0d", i, r), 32'(busy_a[i]), 32'(exp_busy(r, 1'b1)));
      if (i < 2) begin
        chk($sformatf("rd_b[%0d] r%0d", i, r), rd_b[i*32 +: 32], exp_read(r, 1'b0));
        chk($sformatf("busy_b[%0d] r%0d", i, r), 32'(busy_b[i]), 32'(exp_busy(r, 1'b0)));
      end
    end
    chk("claim_ready_a", 32'(cr_a), 32'(exp_ready()));
    chk("claim_ready_b", 32'(cr_b), 32'(exp_ready()));
    chk("busy_any_a", 32'(ba_a), 32'(exp_any()));
    chk("busy_any_b", 32'(ba_b), 32'(exp_any()));
  endtask

  task automatic model_update();
    bit take;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem[i]  = '0;
        pend[i] = 1'b0;
      end
    end else begin
      take = exp_ready() && claim_addr != 5'd0;
      if (we3 && wa3 != 5'd0) mem[wa3] = write_data;
      if (flush) begin
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
      end else begin
        if (we3) pend[wa3] = 1'b0;
        if (take) pend[claim_addr] = 1'b1;
      end
    end
  endtask

  // Inputs change on negedge; outputs are checked 1ns later.
  task automatic step(input bit do_check);
    #1;
    if (do_check) check_all();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1'b1; we3 = 1'b0; wa3 = '0; write_data = '0;
    claim_valid = 1'b0; claim_addr = '0; flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]  = '0;
      pend[i] = 1'b0;
    end
    idle();
    ra = {5'd4, 5'd3, 5'd2, 5'd1};
    rst_n = 1'b0;
    step(1'b0);
    we3 = 1'b1; wa3 = 5'd9; write_data = 32'hBAD0BAD0;
    claim_valid = 1'b1; claim_addr = 5'd9; flush = 1'b1;
    step(1'b1);

    // After reset everything reads zero and nothing is busy.
    idle();
    step(1'b1);
    ra = {5'd9, 5'd9, 5'd9, 5'd9};
    step(1'b1);

    we3 = 1'b1; wa3 = 5'd5; write_data = 32'hDEADBEEF;
    step(1'b1);
    idle(); ra = {5'd0, 5'd0, 5'd5, 5'd5};
    step(1'b1);

    // r0 ignores writes and claims.
    we3 = 1'b1; wa3 = 5'd0; write_data = 32'hFFFFFFFF; ra = '0;
    step(1'b1);
    idle(); claim_valid = 1'b1; claim_addr = 5'd0;
    step(1'b1);
    idle();
    step(1'b1);

    // Bypass: port 1 sees the new r7 value immediately on instance A only.
    we3 = 1'b1; wa3 = 5'd7; write_data = 32'h1234; ra = {5'd5, 5'd7, 5'd7, 5'd5};
    step(1'b1);
    idle();
    step(1'b1);

    // WAW scoreboard sequence on r3.
    claim_valid = 1'b1; claim_addr = 5'd3; ra = {5'd1, 5'd2, 5'd3, 5'd3};
    step(1'b1);
    step(1'b1);
    we3 = 1'b1; wa3 = 5'd3; write_data = 32'h55;
    step(1'b1);
    idle();
    step(1'b1);
    we3 = 1'b1; wa3 = 5'd3; write_data = 32'h66;
    step(1'b1);
    idle();
    step(1'b1);

    // Flush overrides a same-cycle claim.
    claim_valid = 1'b1;
    claim_addr = 5'd1; step(1'b1);
    claim_addr = 5'd2; step(1'b1);
    claim_addr = 5'd4; step(1'b1);
    claim_addr = 5'd6; flush = 1'b1; ra = {5'd6, 5'd4, 5'd2, 5'd1};
    step(1'b1);
    idle();
    step(1'b1);

    // Reset mid-operation drops the claim and the data.
    claim_valid = 1'b1; claim_addr = 5'd2; step(1'b1);
    idle(); we3 = 1'b1; wa3 = 5'd2; write_data = 32'h77; step(1'b1);
    claim_valid = 1'b1; claim_addr = 5'd2; step(1'b1);
    idle(); rst_n = 1'b0; step(1'b1);
    idle(); ra = {5'd2, 5'd2, 5'd2, 5'd2}; step(1'b1);

    // Multi-port: r1..r4 preloaded, r2 busy.
    for (int i = 1; i <= 4; i++) begin
      idle(); we3 = 1'b1; wa3 = 5'(i); write_data = 32'(i * 32'h11);
      step(1'b1);
    end
    idle(); claim_valid = 1'b1; claim_addr = 5'd2; step(1'b1);
    idle(); ra = {5'd4, 5'd3, 5'd2, 5'd1}; step(1'b1);

    // Randomised traffic on a narrow address range to force collisions.
    for (int n = 0; n < 600; n++) begin
      rst_n       = ($urandom_range(0, 59) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      we3         = $urandom_range(0, 1);
      wa3         = 5'($urandom_range(0, 7));
      write_data  = $urandom;
      claim_valid = $urandom_range(0, 1);
      claim_addr  = 5'($urandom_range(0, 7));
      for (int i = 0; i < 4; i++) ra[i*5 +: 5] = 5'($urandom_range(0, 8));
      if ($urandom_range(0, 9) == 0) ra[4:0] = wa3;
      step(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
